// File: rtl/dpram_block_reader_pkg.sv
// Shared types and constants for the dual-port RAM block reader.
// FSM state encoding and read-buffer depth.
package dpram_block_reader_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam logic [2:0] BUF_DEPTH = 3'd2;

endpackage

// File: rtl/dpram_reader_skid_buf.sv
// Two-entry FIFO of {last, data} absorbing the RAM read latency.
// Entry 0 is the registered head; flush empties it in one cycle.
module dpram_reader_skid_buf
  import dpram_block_reader_pkg::*;
#(
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] e0;
  logic [WIDTH-1:0] e1;
  logic [1:0]       cnt;

  assign head  = e0;
  assign count = cnt;

  // Shift-style storage: e0 is always the oldest entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      e0  <= '0;
      e1  <= '0;
      cnt <= 2'd0;
    end else if (flush) begin
      cnt <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) e0 <= din;
          else             e1 <= din;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          e0  <= e1;
          cnt <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt < BUF_DEPTH[1:0]) begin
            e0 <= din;
          end else begin
            e0 <= e1;
            e1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/dpram_block_reader.sv
// Block reader: streams LENGTH words from a 1-cycle-latency RAM.
// Define DPRAM_BLOCK_READER_ABORT_EN to add the abort input.
module dpram_block_reader
  import dpram_block_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef DPRAM_BLOCK_READER_ABORT_EN
  input  logic                  abort,
`endif
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  localparam logic [ADDR_WIDTH-1:0] A_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   N_ONE = (ADDR_WIDTH + 1)'(1);

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   remain_q;
  logic                  inflight_q;
  logic                  inflight_last_q;
  logic                  issue;
  logic                  pop;
  logic                  kill;
  logic [1:0]            count;
  logic [2:0]            occ;
  logic [DATA_WIDTH:0]   head;
  logic                  head_last;

`ifdef DPRAM_BLOCK_READER_ABORT_EN
  assign kill = abort & busy;
`else
  assign kill = 1'b0;
`endif

  assign busy      = (state == READ) || (state == DRAIN);
  assign done      = (state == FINISH);
  assign ram_raddr = addr_q;
  assign m_valid   = (count != 2'd0);
  assign head_last = head[DATA_WIDTH];
  assign m_data    = head[DATA_WIDTH-1:0];
  assign m_last    = head_last & m_valid;
  assign pop       = m_valid & m_ready;

  // Slots committed after this cycle: buffered + landing - leaving.
  assign occ = {1'b0, count}
             + {2'b00, inflight_q}
             - {2'b00, pop};

  // Next state and read-issue decision.
  // A zero-length block spends one busy cycle in READ before FINISH.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = READ;
      end
      READ: begin
        if (remain_q == '0) begin
          state_nxt = FINISH;
        end else if (occ < BUF_DEPTH) begin
          issue = 1'b1;
          if (remain_q == N_ONE) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && m_last) state_nxt = FINISH;
      end
      FINISH: begin
        state_nxt = IDLE;
      end
    endcase
    if (kill) begin
      state_nxt = FINISH;
      issue     = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Address counter and words-left-to-issue counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q   <= '0;
      remain_q <= '0;
    end else if (state == IDLE && start) begin
      addr_q   <= start_addr;
      remain_q <= length;
    end else if (issue) begin
      addr_q   <= addr_q + A_ONE;
      remain_q <= remain_q - N_ONE;
    end
  end

  // In-flight flag: ram_dout this cycle answers last cycle's issue.
  always_ff @(posedge clk) begin
    if (reset || kill) begin
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      inflight_q      <= issue;
      inflight_last_q <= issue && (remain_q == N_ONE);
    end
  end

  dpram_reader_skid_buf #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_buf (
    .clk   (clk),
    .reset (reset),
    .flush (kill),
    .push  (inflight_q),
    .din   ({inflight_last_q, ram_dout}),
    .pop   (pop),
    .head  (head),
    .count (count)
  );

endmodule

// File: tb/tb_dpram_block_reader.sv
// Scoreboard bench for dpram_block_reader with a behavioural RAM.
// Directed blocks: plain, wrap, backpressure, empty, reset, abort.
module tb_dpram_block_reader;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW:0]   length = '0;
  logic          busy;
  logic          done;
  logic [AW-1:0] ram_raddr;
  logic [DW-1:0] ram_dout = '0;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [DW-1:0] m_data;
  logic          m_last;
`ifdef DPRAM_BLOCK_READER_ABORT_EN
  logic          abort = 1'b0;
`endif

  logic [DW-1:0] mem [32];
  logic [DW:0]   exp_q [$];
  logic [DW:0]   e;
  int checks = 0;
  int errors = 0;
  int beats_seen = 0;
  int rc = 0;
  int ready_mode = 0;
  logic          hold_v = 1'b0;
  logic [DW-1:0] hold_d = '0;
  logic          hold_l = 1'b0;

  dpram_block_reader #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
`ifdef DPRAM_BLOCK_READER_ABORT_EN
    .abort      (abort),
`endif
    .start      (start),
    .start_addr (start_addr),
    .length     (length),
    .busy       (busy),
    .done       (done),
    .ram_raddr  (ram_raddr),
    .ram_dout   (ram_dout),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last)
  );

  always #5 clk = ~clk;

  initial begin
    for (int k = 0; k < 32; k++) mem[k] = 32'h100 + k;
  end

  always @(posedge clk) ram_dout <= mem[ram_raddr];

  always begin
    @(posedge clk);
    #1;
    rc = rc + 1;
    if (ready_mode == 0) m_ready = 1'b1;
    else                 m_ready = ((rc % 3) == 0);
  end

  always @(negedge clk) begin
    if (reset) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        checks++;
        if (!m_valid || m_data !== hold_d || m_last !== hold_l) begin
          errors++;
          $display("FAIL stall_stable actual v=%0b d=%h l=%0b required d=%h l=%0b",
                   m_valid, m_data, m_last, hold_d, hold_l);
        end
      end
      if (m_valid && m_ready) begin
        checks++;
        beats_seen++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected actual=%h required none", {m_last, m_data});
        end else begin
          e = exp_q.pop_front();
          if ({m_last, m_data} !== e) begin
            errors++;
            $display("FAIL beat actual=%h required=%h", {m_last, m_data}, e);
          end
        end
      end
      hold_v = m_valid && !m_ready;
      hold_d = m_data;
      hold_l = m_last;
    end
  end

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic pulse_start(input int a, input int len);
    @(posedge clk);
    #1;
    start      = 1'b1;
    start_addr = a[AW-1:0];
    length     = len[AW:0];
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic push_exp(input int a, input int len);
    for (int i = 0; i < len; i++)
      exp_q.push_back({(i == len - 1), mem[(a + i) % 32]});
  endtask

  // Offsets k count cycles after the start-sampling edge (k=1 first).
  task automatic run_block(input int a, input int len, input int rm,
                           input bit poke, input int e_first,
                           input int e_last, input int e_done,
                           input int e_busy);
    int first_k = -1;
    int last_k = -1;
    int done_k = -1;
    int busy_n = 0;
    int done_n = 0;
    int busy_at_done = 0;
    ready_mode = rm;
    push_exp(a, len);
    pulse_start(a, len);
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (m_valid && first_k < 0) first_k = k;
      if (m_valid && m_ready && m_last) last_k = k;
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (done_k < 0) begin
          done_k = k;
          busy_at_done = int'(busy);
        end
      end
      if (poke) begin
        if (k == 4) begin
          start      = 1'b1;
          start_addr = 5'd7;
          length     = 6'd3;
        end else if (k == 5) begin
          start = 1'b0;
        end
      end
      if (done_k > 0 && k >= done_k + 2) break;
    end
    if (e_first != -2) chk("first_valid", first_k, e_first);
    if (e_last != -2)  chk("last_beat", last_k, e_last);
    if (e_done != -2)  chk("done_cycle", done_k, e_done);
    if (e_busy != -2)  chk("busy_cycles", busy_n, e_busy);
    chk("done_pulses", done_n, 1);
    chk("busy_at_done", busy_at_done, 0);
    if (len > 0) chk("done_after_last", done_k, last_k + 1);
    chk("queue_empty", exp_q.size(), 0);
    ready_mode = 0;
  endtask

  task automatic wait_third_beat(output int found);
    found = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (m_valid && beats_seen == 2) begin
        found = 1;
        break;
      end
    end
  endtask

  initial begin
    int found;
    int dn;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_valid", int'(m_valid), 0);
    chk("rst_last", int'(m_last), 0);
    chk("rst_data", int'(m_data), 0);
    chk("rst_raddr", int'(ram_raddr), 0);
    reset = 1'b0;

    run_block(3, 4, 0, 1'b0, 3, 6, 7, 6);
    run_block(30, 4, 0, 1'b0, 3, 6, 7, 6);
    run_block(0, 8, 1, 1'b1, -2, -2, -2, -2);
    run_block(9, 0, 0, 1'b0, -1, -1, 2, 1);

    ready_mode = 0;
    beats_seen = 0;
    push_exp(12, 6);
    pulse_start(12, 6);
    wait_third_beat(found);
    chk("rst_third_beat", found, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    chk("midrst_valid", int'(m_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    dn = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("midrst_no_done", dn, 0);
    run_block(0, 2, 0, 1'b0, 3, 4, 5, 4);

`ifdef DPRAM_BLOCK_READER_ABORT_EN
    beats_seen = 0;
    push_exp(20, 10);
    pulse_start(20, 10);
    wait_third_beat(found);
    chk("abort_third_beat", found, 1);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    exp_q.delete();
    chk("abort_valid", int'(m_valid), 0);
    dn = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("abort_done_pulses", dn, 1);
    chk("abort_idle_busy", int'(busy), 0);
    run_block(5, 3, 0, 1'b0, 3, 5, 6, 5);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
